uart_tx_control: RTL

UART_TX_CONTROL -- requirements
Module: uart_tx_control

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_control_if.sv | 44 ++++
 rtl/baud_tick_gen.sv | 40 ++++
 rtl/uart_tx_control.sv | 106 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART transmit control package.
// Holds the controller FSM state type and the frame-length helper shared by
// the controller and anything that needs to know how long a frame is.
//   txState_e  : IDLE -> LOAD -> SEND -> CLEAR -> IDLE
//   frameBits(): start bit + data bits + even-parity bit + stop bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        CLEAR = 2'd3
    } txState_e;

    function automatic int frameBits(input int wordLength);
        return wordLength + 3;
    endfunction

endpackage

// File: rtl/uart_tx_control_if.sv
// Control bundle between the UART TX controller and its requester/datapath.
//   iStart     : frame request from the requester (level, sampled in IDLE)
//   oLoad      : parallel-load strobe for the TX shift register
//   oShift     : one-cycle pulse at each serial bit boundary
//   oTxActive  : selects the shifter onto the line (line idles high when 0)
//   oSyncReset : one-cycle clear of the datapath registers and counters
//   oBusy      : high whenever the controller is not idle
//   oDone      : one-cycle end-of-frame pulse
// Handshake: iStart is a plain level request with no ready/acknowledge; it is
// taken on any rising edge where the controller is idle and ignored (not
// queued) otherwise. oBusy low means the next edge will accept iStart.
// The master modport is the requester/datapath side, the slave modport is
// the controller.
interface uart_tx_control_if;

    logic iStart;
    logic oLoad;
    logic oShift;
    logic oTxActive;
    logic oSyncReset;
    logic oBusy;
    logic oDone;

    modport master (
        output iStart,
        input  oLoad,
        input  oShift,
        input  oTxActive,
        input  oSyncReset,
        input  oBusy,
        input  oDone
    );

    modport slave (
        input  iStart,
        output oLoad,
        output oShift,
        output oTxActive,
        output oSyncReset,
        output oBusy,
        output oDone
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator for the UART TX controller.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps; tick is high for the one
// cycle in which the count sits at its terminal value. The tick is decoded
// from the count register and the enable, so it carries no input path beyond
// the controller state that drives enable.
//   clk    : clock
//   reset  : synchronous active-high reset (count to 0)
//   enable : count while high (controller in SEND)
//   clear  : synchronous clear of the count
//   tick   : one-cycle pulse at each bit boundary
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LastCount) begin
                count <= '0;
            end else begin
                count <= count + CntW'(1);
            end
        end
    end

    assign tick = enable && (count == LastCount);

endmodule

// File: rtl/uart_tx_control.sv
// UART transmit controller.
// Sequences one serial frame (start, WORD_LENGTH data, even parity, stop):
// a one-cycle load strobe, FRAME_BITS bit periods of CLKS_PER_BIT cycles with
// a shift pulse at the end of each, then a one-cycle clear/done cycle.
//   clk      : clock, all state on the rising edge
//   reset    : synchronous active-high reset, overrides every transition
//   bus      : control bundle (slave side), see uart_tx_control_if
//   dbgState : current FSM state, for observation only
// Every output is decoded from the state register and the counter registers;
// iStart only influences the next state.
module uart_tx_control
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_control_if.slave bus,
    output txState_e         dbgState
);

    localparam int FrameBits = frameBits(WORD_LENGTH);
    localparam int BitCntW   = $clog2(FrameBits + 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(FrameBits - 1);

    txState_e            state;
    txState_e            nextState;
    logic [BitCntW-1:0]  bitCount;
    logic                baudEnable;
    logic                baudClear;
    logic                baudTick;

    // Enable/clear come straight from the state register so the tick path
    // never loops back through the next-state logic.
    assign baudEnable = (state == SEND);
    assign baudClear  = (state == CLEAR);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uBaud (
        .clk    (clk),
        .reset  (reset),
        .enable (baudEnable),
        .clear  (baudClear),
        .tick   (baudTick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Counts completed bits; it reaches FrameBits on the last tick and is
    // cleared in the CLEAR cycle that follows.
    always_ff @(posedge clk) begin
        if (reset || (state == CLEAR)) begin
            bitCount <= '0;
        end else if (baudTick) begin
            bitCount <= bitCount + BitCntW'(1);
        end
    end

    always_comb begin
        nextState      = state;
        bus.oLoad      = 1'b0;
        bus.oShift     = 1'b0;
        bus.oTxActive  = 1'b0;
        bus.oSyncReset = 1'b0;
        bus.oDone      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                bus.oLoad = 1'b1;
                nextState = SEND;
            end
            SEND: begin
                bus.oTxActive = 1'b1;
                bus.oShift    = baudTick;
                // The tick that completes the final bit ends the frame.
                if (baudTick && (bitCount == LastBit)) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                bus.oSyncReset = 1'b1;
                bus.oDone      = 1'b1;
                nextState      = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        bus.oBusy = (state != IDLE);
    end

    assign dbgState = state;

endmodule
